// File: rtl/handshake_constant_seq.sv
// Elastic constant source: each accepted control token yields the next value of
// VALUE, VALUE+STEP, ... (COUNT entries, then wrap). Define
// HANDSHAKE_CONSTANT_SEQ_BYPASS_EN to drop the output register (zero-latency build).
module handshake_constant_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int VALUE      = 0,
    parameter int STEP       = 0,
    parameter int COUNT      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    input  logic                  restart,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam int                    IDX_W   = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [DATA_WIDTH-1:0] C_VALUE = DATA_WIDTH'(VALUE);
    localparam logic [DATA_WIDTH-1:0] C_STEP  = DATA_WIDTH'(STEP);
    localparam logic [IDX_W-1:0]      C_LAST  = IDX_W'(COUNT - 1);

    logic [DATA_WIDTH-1:0] r_cur;
    logic [DATA_WIDTH-1:0] w_cur_nxt;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic                  w_accept;

    // Sequence advance; restart wins over the accept-driven step.
    always_comb begin
        w_cur_nxt = r_cur;
        w_idx_nxt = r_idx;
        if (restart) begin
            w_cur_nxt = C_VALUE;
            w_idx_nxt = {IDX_W{1'b0}};
        end else if (w_accept) begin
            if (r_idx == C_LAST) begin
                w_cur_nxt = C_VALUE;
                w_idx_nxt = {IDX_W{1'b0}};
            end else begin
                w_cur_nxt = r_cur + C_STEP;
                w_idx_nxt = r_idx + IDX_W'(1);
            end
        end else begin
            w_cur_nxt = r_cur;
            w_idx_nxt = r_idx;
        end
    end

    // Sequence state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cur <= C_VALUE;
            r_idx <= {IDX_W{1'b0}};
        end else begin
            r_cur <= w_cur_nxt;
            r_idx <= w_idx_nxt;
        end
    end

`ifdef HANDSHAKE_CONSTANT_SEQ_BYPASS_EN
    assign w_accept   = ctrl_valid && outs_ready;
    assign ctrl_ready = outs_ready;
    assign outs_valid = ctrl_valid;
    assign outs       = r_cur;
`else
    logic                  r_full;
    logic                  w_full_nxt;
    logic [DATA_WIDTH-1:0] r_data;

    // Ready depends only on the slot and downstream, never on ctrl_valid.
    assign ctrl_ready = !r_full || outs_ready;
    assign w_accept   = ctrl_valid && ctrl_ready;
    assign outs_valid = r_full;
    assign outs       = r_data;

    // Slot occupancy: accept refills (even while draining), drain alone empties.
    always_comb begin
        w_full_nxt = r_full;
        if (w_accept) begin
            w_full_nxt = 1'b1;
        end else if (r_full && outs_ready) begin
            w_full_nxt = 1'b0;
        end else begin
            w_full_nxt = r_full;
        end
    end

    // Output slot registers; the token captures cur before any advance or restart.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_full <= 1'b0;
            r_data <= {DATA_WIDTH{1'b0}};
        end else begin
            r_full <= w_full_nxt;
            if (w_accept) begin
                r_data <= r_cur;
            end else begin
                r_data <= r_data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_handshake_constant_seq.sv
// Self-checking bench for handshake_constant_seq (registered build), DATA_WIDTH=4,
// VALUE=7, STEP=3, COUNT=4; directed test-plan steps followed by random traffic.
module tb_handshake_constant_seq;

    localparam int DW  = 4;
    localparam int VAL = 7;
    localparam int STP = 3;
    localparam int CNT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ctrl_valid = 1'b0;
    logic          ctrl_ready;
    logic          restart = 1'b0;
    logic [DW-1:0] outs;
    logic          outs_valid;
    logic          outs_ready = 1'b0;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: position in the sequence plus the output slot contents.
    int m_pos  = 0;
    int m_full = 0;
    int m_data = 0;

    handshake_constant_seq #(
        .DATA_WIDTH(DW), .VALUE(VAL), .STEP(STP), .COUNT(CNT)
    ) dut (
        .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
        .restart(restart), .outs(outs), .outs_valid(outs_valid), .outs_ready(outs_ready)
    );

    always #5 clk = ~clk;

    function automatic int seq_val(input int pos);
        return (VAL + STP * pos) % (1 << DW);
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pos  = 0;
        m_full = 0;
        m_data = 0;
    endtask

    // One cycle starting just after a falling edge: drive, check ready, clock, check slot.
    task automatic step(input logic cv, input logic rdy, input logic rs);
        int acc;
        ctrl_valid = cv;
        outs_ready = rdy;
        restart    = rs;
        #1;
        check("ctrl_ready", int'(ctrl_ready), (m_full == 0 || rdy) ? 1 : 0);
        acc = (cv && (m_full == 0 || rdy)) ? 1 : 0;
        @(posedge clk);
        if (acc != 0) begin
            m_data = seq_val(m_pos);
            m_full = 1;
        end else if (m_full != 0 && rdy) begin
            m_full = 0;
        end
        if (rs) m_pos = 0;
        else if (acc != 0) m_pos = (m_pos + 1) % CNT;
        @(negedge clk);
        check("outs_valid", int'(outs_valid), m_full);
        check("outs", int'(outs), m_data);
    endtask

    initial begin
        int wrap_exp[6];
        wrap_exp = '{7, 10, 13, 0, 7, 10};

        // Reset held for three cycles
        repeat (3) begin
            @(negedge clk);
            check("rst_valid", int'(outs_valid), 0);
            check("rst_outs", int'(outs), 0);
            check("rst_ready", int'(ctrl_ready), 1);
        end
        rst = 1'b1;

        // Sequence wrap at full throughput
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 1'b0);
            check("wrap_seq", int'(outs), wrap_exp[i]);
            check("wrap_valid", int'(outs_valid), 1);
        end

        // Back-pressure holds the token and blocks ctrl
        step(1'b0, 1'b1, 1'b1);
        check("drain_empty", int'(outs_valid), 0);
        step(1'b1, 1'b0, 1'b0);
        check("bp_first", int'(outs), 7);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0);
            check("bp_hold", int'(outs), 7);
            check("bp_ready", int'(ctrl_ready), 0);
        end
        step(1'b1, 1'b1, 1'b0);
        check("bp_next1", int'(outs), 10);
        step(1'b1, 1'b1, 1'b0);
        check("bp_next2", int'(outs), 13);

        // Restart coinciding with the accept of the token carrying 10
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        check("rs_pre", int'(outs), 7);
        step(1'b1, 1'b1, 1'b1);
        check("rs_collide", int'(outs), 10);
        step(1'b1, 1'b1, 1'b0);
        check("rs_after", int'(outs), 7);

        // Asynchronous reset while a token is held
        check("mid_valid_pre", int'(outs_valid), 1);
        #2 rst = 1'b0;
        #1;
        check("mid_async_valid", int'(outs_valid), 0);
        check("mid_async_outs", int'(outs), 0);
        model_reset();
        @(negedge clk);
        check("mid_hold_valid", int'(outs_valid), 0);
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        check("mid_first", int'(outs), 7);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
